mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised MEM-stage load/store controller for az_cpu. Takes the EX-stage result and memory op, and drives a registered, wait-state-tolerant bus access with byte enables. It extracts and sign/zero-extends load data, stalls the pipeline until the access completes, and flags misalignment and bus timeouts. Non-memory ops pass `ex_out` straight through.

## Interface
- XLEN, 32: datapath width; 32 or 64.
- TIMEOUT_CYC, 255: maximum cycles spent waiting for `bus_rdy_n` before abort; 1..65535.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ex_en  in  1  EX/MEM pipeline register valid.
- ex_mem_op  in  2  0 none, 1 load, 2 store, 3 reserved (same as none).
- ex_mem_size  in  2  0 byte, 1 half, 2 word, 3 dword (legal only when XLEN=64).
- ex_mem_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- ex_mem_wdata  in  XLEN  store data, right-aligned.
- ex_out  in  XLEN  ALU result; the byte address for memory ops.
- bus_addr  out  XLEN-log2(XLEN/8)  unit address, `ex_out[XLEN-1:log2(XLEN/8)]`.
- bus_as_n  out  1  address strobe, active low.
- bus_rw  out  1  1 write, 0 read.
- bus_be  out  XLEN/8  byte enables, little-endian.
- bus_wdata  out  XLEN  lane-replicated store data.
- bus_rdata  in  XLEN  read data, valid when `bus_rdy_n`=0.
- bus_rdy_n  in  1  access complete, active low.
- out  out  XLEN  result to the WB stage.
- stall  out  1  holds the IF..MEM pipeline registers.
- miss_align  out  1  misaligned or illegal-size access, combinational.
- bus_err  out  1  timeout flag, valid in DONE.

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset puts the FSM in IDLE.
- `req` = ex_en & (op==1 | op==2) & aligned & legal size in IDLE.
- Aligned means:
  - half: addr[0]==0
  - word: addr[1:0]==0
  - dword: addr[2:0]==0
- Size 3 with XLEN=32 is illegal.
- IDLE, misaligned or illegal memory op: `miss_align`=1, `out`=0, no bus access, `stall`=0.
- IDLE, non-memory op or ex_en=0: `out`=`ex_out`, `miss_align`=0, `stall`=0.
- IDLE & `req`: register the bus fields, set `bus_as_n`=0, go to ACCESS, load the timeout counter with 0.
- Byte enables use `off` = the low address bits:
  - byte: 1<<off
  - half: 3<<off
  - word: 0xF<<off
  - dword: all ones
- Store data is the size field replicated across all lanes.
- ACCESS & `bus_rdy_n`=0: capture `bus_rdata` on a load, set `bus_as_n`=1, go to DONE.
- ACCESS & `bus_rdy_n`=1: increment the counter. When the counter equals TIMEOUT_CYC-1, set `bus_as_n`=1, set the error flag, go to DONE.
- Load extraction: `rdata >> (8*off)`, truncate to the size, then sign- or zero-extend.
- DONE: drive registered `out` (load data, ex_out for a store, 0 on error), drive `bus_err`, set `stall`=0, go to IDLE unconditionally.
  - The still-present ex_* fields are ignored in DONE, so there is no re-issue.
- Reset mid-access: the FSM goes to IDLE at the next edge, `bus_as_n` returns to 1, the captured data is discarded, and there is no DONE pulse.

## Timing
- Reset values:
  - `bus_as_n`=1, `bus_rw`=0, `bus_be`=0, `bus_addr`=0, `bus_wdata`=0
  - `bus_err`=0, `stall`=0, `out`=`ex_out` (IDLE)
- `stall` = `req` | (state==ACCESS). It is combinational and asserted from the request cycle C0.
- C0 is the request cycle. From C1, `bus_as_n`=0, stable until the completion edge.
- A zero-wait slave asserts `bus_rdy_n`=0 in C1, making C2 the DONE cycle. Minimum latency is 3 cycles, 2 of them stalled.
- A slave with n wait states gives DONE in C2+n.
- Timeout: `bus_as_n` is low for exactly TIMEOUT_CYC cycles, then DONE has `bus_err`=1.
- `bus_rdy_n` is ignored outside ACCESS.
- If `bus_rdy_n`=0 arrives in the same cycle as the timeout, the completion wins and `bus_err`=0.
- Misalignment never stalls. The exception logic samples `miss_align` in C0.

## Test plan
- Reset, then ex_en=1 op=0 ex_out=0x1234 -> `out`=0x1234, `stall`=0, `bus_as_n`=1.
- LW at 0x100, zero-wait, rdata=0xDEADBEEF -> `bus_addr`=0x40, `bus_be`=0xF; `stall` high in C0–C1; DONE in C2 with `out`=0xDEADBEEF.
- LB at 0x103, rdata=0x80FFFFFF -> `bus_be`=0x8, `out`=0xFFFFFF80. The same access as LBU -> `out`=0x00000080.
- SH at 0x202, wdata=0x0000ABCD, 3 wait states -> `bus_rw`=1, `bus_be`=0xC, `bus_wdata`=0xABCDABCD; DONE in C5.
- LW at 0x101 -> `miss_align`=1, `stall`=0, `bus_as_n` stays 1. LH at 0x101 -> `miss_align`=1. Size 3 with XLEN=32 -> `miss_align`=1.
- TIMEOUT_CYC=4, slave never ready -> `bus_as_n` low for 4 cycles, then DONE with `bus_err`=1, `out`=0.
- Reset asserted mid-ACCESS -> next edge: IDLE, `bus_as_n`=1, no DONE.

Source files
------------

// File: rtl/mem_access_unit.sv
// Purpose     : MEM-stage load/store controller. It drives one registered bus access per memory op,
//               then extracts, aligns and extends the load data.
// Latency     : request cycle C0, bus strobe from C1, result in DONE at C2+n for n slave wait states.
//               A slave that never answers is abandoned after TIMEOUT_CYC strobe cycles.
// Backpressure: stall holds IF..MEM from the request cycle until the access completes.
//               Misaligned ops never stall.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   ex_en, ex_mem_op/size/
//   ex_mem_unsigned            - EX/MEM memory op descriptor
//   ex_mem_wdata, ex_out       - store data (right-aligned), ALU result / byte address
//   bus_addr/as_n/rw/be/wdata  - registered bus request (unit address, strobe, dir, lanes, data)
//   bus_rdata, bus_rdy_n       - slave read data and completion
//   out, stall, miss_align,
//   bus_err                    - WB result, pipeline hold, alignment fault, timeout flag
module mem_access_unit #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ex_en,
  input  logic [1:0]                        ex_mem_op,
  input  logic [1:0]                        ex_mem_size,
  input  logic                              ex_mem_unsigned,
  input  logic [XLEN-1:0]                   ex_mem_wdata,
  input  logic [XLEN-1:0]                   ex_out,
  output logic [XLEN-$clog2(XLEN/8)-1:0]    bus_addr,
  output logic                              bus_as_n,
  output logic                              bus_rw,
  output logic [XLEN/8-1:0]                 bus_be,
  output logic [XLEN-1:0]                   bus_wdata,
  input  logic [XLEN-1:0]                   bus_rdata,
  input  logic                              bus_rdy_n,
  output logic [XLEN-1:0]                   out,
  output logic                              stall,
  output logic                              miss_align,
  output logic                              bus_err
);

  localparam int OFFW = $clog2(XLEN/8);
  localparam int BEW  = XLEN/8;
  localparam int AW   = XLEN - OFFW;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic            rw;
    logic [BEW-1:0]  be;
    logic [XLEN-1:0] wdata;
  } bus_req_t;

  // Everything the load extractor needs once the EX fields are gone.
  typedef struct packed {
    logic [1:0]      size;
    logic            uns;
    logic [OFFW-1:0] off;
  } ld_meta_t;

  state_t          state_q, state_d;
  bus_req_t        bus_q, bus_d;
  ld_meta_t        meta_q, meta_d;
  logic            as_n_q, as_n_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [XLEN-1:0] out_q, out_d;
  logic            err_q, err_d;

  logic            is_mem;
  logic            aligned;
  logic            legal;
  logic            req;
  logic [OFFW-1:0] off_in;
  logic [BEW-1:0]  be_new;
  logic [XLEN-1:0] wdata_new;
  logic [XLEN-1:0] ld_sh;
  logic [XLEN-1:0] ld_left;
  logic [XLEN-1:0] ld_val;
  logic [6:0]      kill;

  // Request decode: alignment, size legality, lanes and replicated store data.
  always_comb begin
    is_mem    = ex_mem_op == 2'd1 || ex_mem_op == 2'd2;
    off_in    = ex_out[OFFW-1:0];
    aligned   = 1'b1;
    legal     = 1'b1;
    be_new    = '0;
    wdata_new = '0;
    unique case (ex_mem_size)
      2'd0: begin
        be_new    = BEW'(1) << off_in;
        wdata_new = {(XLEN/8){ex_mem_wdata[7:0]}};
      end
      2'd1: begin
        aligned   = ~ex_out[0];
        be_new    = BEW'(3) << off_in;
        wdata_new = {(XLEN/16){ex_mem_wdata[15:0]}};
      end
      2'd2: begin
        aligned   = ex_out[1:0] == 2'b00;
        be_new    = BEW'(4'hF) << off_in;
        wdata_new = {(XLEN/32){ex_mem_wdata[31:0]}};
      end
      default: begin
        aligned   = ex_out[2:0] == 3'b000;
        legal     = XLEN == 64;
        be_new    = '1;
        wdata_new = ex_mem_wdata;
      end
    endcase
    req        = state_q == IDLE && ex_en && is_mem && aligned && legal;
    miss_align = state_q == IDLE && ex_en && is_mem && !(aligned && legal);
    stall      = req || state_q == ACCESS;
  end

  // Load extraction: shift the addressed lane down, then push the value to the top
  // and back down so that one arithmetic/logical shift does truncation and extension.
  always_comb begin
    ld_sh = bus_rdata >> {meta_q.off, 3'b000};
    unique case (meta_q.size)
      2'd0:    kill = 7'(XLEN - 8);
      2'd1:    kill = 7'(XLEN - 16);
      2'd2:    kill = 7'(XLEN - 32);
      default: kill = 7'd0;
    endcase
    ld_left = ld_sh << kill;
    if (meta_q.uns) ld_val = ld_left >> kill;
    else            ld_val = $signed(ld_left) >>> kill;
  end

  // FSM next state and registered bus/result fields.
  always_comb begin
    state_d = state_q;
    bus_d   = bus_q;
    meta_d  = meta_q;
    as_n_d  = as_n_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          bus_d.addr  = ex_out[XLEN-1:OFFW];
          bus_d.rw    = ex_mem_op == 2'd2;
          bus_d.be    = be_new;
          bus_d.wdata = (ex_mem_op == 2'd2) ? wdata_new : '0;
          meta_d.size = ex_mem_size;
          meta_d.uns  = ex_mem_unsigned;
          meta_d.off  = off_in;
          as_n_d      = 1'b0;
          cnt_d       = '0;
          out_d       = ex_out;   // store result; overwritten by load data or error
          err_d       = 1'b0;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        // Completion is checked first so a late ready beats the timeout.
        if (!bus_rdy_n) begin
          if (!bus_q.rw) out_d = ld_val;
          as_n_d  = 1'b1;
          state_d = DONE;
        end else if (cnt_q == TMO_LAST) begin
          as_n_d  = 1'b1;
          err_d   = 1'b1;
          out_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE:    state_d = IDLE;  // EX fields still present here are deliberately ignored
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bus_q   <= '0;
      meta_q  <= '0;
      as_n_q  <= 1'b1;
      cnt_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      meta_q  <= meta_d;
      as_n_q  <= as_n_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign bus_addr  = bus_q.addr;
  assign bus_rw    = bus_q.rw;
  assign bus_be    = bus_q.be;
  assign bus_wdata = bus_q.wdata;
  assign bus_as_n  = as_n_q;
  assign bus_err   = state_q == DONE && err_q;

  always_comb begin
    out = ex_out;
    unique case (state_q)
      IDLE:    out = miss_align ? '0 : ex_out;
      DONE:    out = out_q;
      default: out = ex_out;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_en;
  logic [1:0]  ex_mem_op;
  logic [1:0]  ex_mem_size;
  logic        ex_mem_unsigned;
  logic [31:0] ex_mem_wdata;
  logic [31:0] ex_out;
  logic [29:0] bus_addr;
  logic        bus_as_n;
  logic        bus_rw;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_rdy_n;
  logic [31:0] out;
  logic        stall;
  logic        miss_align;
  logic        bus_err;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_unit #(.XLEN(32), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset(reset), .ex_en(ex_en), .ex_mem_op(ex_mem_op),
    .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned),
    .ex_mem_wdata(ex_mem_wdata), .ex_out(ex_out), .bus_addr(bus_addr),
    .bus_as_n(bus_as_n), .bus_rw(bus_rw), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_rdy_n(bus_rdy_n), .out(out), .stall(stall),
    .miss_align(miss_align), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic en, input logic [1:0] op, input logic [1:0] sz,
                       input logic u, input logic [31:0] a, input logic [31:0] wd);
    ex_en = en; ex_mem_op = op; ex_mem_size = sz; ex_mem_unsigned = u;
    ex_out = a; ex_mem_wdata = wd;
    #1;
  endtask

  // Zero-wait byte load at 0x103, checked from C0 to DONE.
  task automatic byte_load(input string tag, input logic u, input logic [31:0] exp_out);
    cyc(); drive(1'b1, 2'd1, 2'd0, u, 32'h103, 32'h0);
    chk({tag, "_c0_stall"}, stall, 1);
    cyc();
    chk({tag, "_be"}, bus_be, 4'h8);
    chk({tag, "_addr"}, bus_addr, 30'h40);
    bus_rdy_n = 1'b0; bus_rdata = 32'h80FFFFFF; #1;
    cyc();
    bus_rdy_n = 1'b1; bus_rdata = 32'h0; #1;
    chk({tag, "_out"}, out, exp_out);
    chk({tag, "_done_stall"}, stall, 0);
    drive(1'b0, 2'd0, 2'd0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b1; bus_rdata = 32'h0; bus_rdy_n = 1'b1;
    drive(1'b0, 2'd0, 2'd0, 1'b0, 32'h55, 32'h0);
    cyc(); cyc();
    chk("rst_as_n", bus_as_n, 1);
    chk("rst_rw", bus_rw, 0);
    chk("rst_be", bus_be, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_stall", stall, 0);
    chk("rst_out", out, 32'h55);
    reset = 1'b0;

    // Pass-through and reserved op
    cyc(); drive(1'b1, 2'd0, 2'd0, 1'b0, 32'h1234, 32'h0);
    chk("pass_out", out, 32'h1234);
    chk("pass_stall", stall, 0);
    chk("pass_as_n", bus_as_n, 1);
    chk("pass_miss", miss_align, 0);
    drive(1'b1, 2'd3, 2'd2, 1'b0, 32'h101, 32'h0);
    chk("rsvd_out", out, 32'h101);
    chk("rsvd_miss", miss_align, 0);
    chk("rsvd_stall", stall, 0);

    // LW 0x100, zero wait states
    cyc(); drive(1'b1, 2'd1, 2'd2, 1'b0, 32'h100, 32'h0);
    chk("lw_c0_stall", stall, 1);
    chk("lw_c0_as_n", bus_as_n, 1);
    chk("lw_c0_miss", miss_align, 0);
    cyc();
    chk("lw_c1_as_n", bus_as_n, 0);
    chk("lw_c1_addr", bus_addr, 30'h40);
    chk("lw_c1_be", bus_be, 4'hF);
    chk("lw_c1_rw", bus_rw, 0);
    chk("lw_c1_stall", stall, 1);
    bus_rdy_n = 1'b0; bus_rdata = 32'hDEADBEEF; #1;
    cyc();
    bus_rdy_n = 1'b1; bus_rdata = 32'h0; #1;
    chk("lw_done_out", out, 32'hDEADBEEF);
    chk("lw_done_stall", stall, 0);
    chk("lw_done_as_n", bus_as_n, 1);
    chk("lw_done_err", bus_err, 0);
    drive(1'b0, 2'd0, 2'd0, 1'b0, 32'h0, 32'h0);

    // LB / LBU at 0x103
    byte_load("lb", 1'b0, 32'hFFFFFF80);
    byte_load("lbu", 1'b1, 32'h00000080);

    // SH 0x202 with three wait states; ready lands on the last counter value
    cyc(); drive(1'b1, 2'd2, 2'd1, 1'b0, 32'h202, 32'h0000ABCD);
    chk("sh_c0_stall", stall, 1);
    cyc();
    chk("sh_rw", bus_rw, 1);
    chk("sh_be", bus_be, 4'hC);
    chk("sh_wdata", bus_wdata, 32'hABCDABCD);
    chk("sh_addr", bus_addr, 30'h80);
    for (int i = 2; i <= 4; i++) begin
      cyc();
      chk("sh_wait_as_n", bus_as_n, 0);
      chk("sh_wait_stall", stall, 1);
    end
    bus_rdy_n = 1'b0; #1;
    cyc();
    bus_rdy_n = 1'b1; #1;
    chk("sh_c5_out", out, 32'h202);
    chk("sh_c5_err", bus_err, 0);
    chk("sh_c5_stall", stall, 0);
    chk("sh_c5_as_n", bus_as_n, 1);
    drive(1'b0, 2'd0, 2'd0, 1'b0, 32'h0, 32'h0);

    // Misaligned and illegal-size ops
    cyc(); drive(1'b1, 2'd1, 2'd2, 1'b0, 32'h101, 32'h0);
    chk("lw_mis_miss", miss_align, 1);
    chk("lw_mis_stall", stall, 0);
    chk("lw_mis_out", out, 0);
    cyc();
    chk("lw_mis_as_n", bus_as_n, 1);
    drive(1'b1, 2'd1, 2'd1, 1'b0, 32'h101, 32'h0);
    chk("lh_mis_miss", miss_align, 1);
    drive(1'b1, 2'd1, 2'd3, 1'b0, 32'h100, 32'h0);
    chk("ld_size3_miss", miss_align, 1);
    chk("ld_size3_stall", stall, 0);
    drive(1'b1, 2'd2, 2'd2, 1'b0, 32'h202, 32'h0);
    chk("sw_mis_miss", miss_align, 1);
    cyc();
    chk("mis_no_access", bus_as_n, 1);
    drive(1'b0, 2'd0, 2'd0, 1'b0, 32'h0, 32'h0);

    // Timeout: slave never ready, strobe low for exactly 4 cycles
    cyc(); drive(1'b1, 2'd1, 2'd2, 1'b0, 32'h300, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("tmo_as_n", bus_as_n, 0);
      chk("tmo_stall", stall, 1);
    end
    cyc();
    chk("tmo_err", bus_err, 1);
    chk("tmo_out", out, 0);
    chk("tmo_as_n_hi", bus_as_n, 1);
    chk("tmo_stall_lo", stall, 0);
    drive(1'b0, 2'd0, 2'd0, 1'b0, 32'h0, 32'h0);
    cyc();
    chk("tmo_err_clr", bus_err, 0);

    // Reset mid-ACCESS discards the access
    cyc(); drive(1'b1, 2'd1, 2'd2, 1'b0, 32'h400, 32'h0);
    cyc();
    chk("rma_c1_as_n", bus_as_n, 0);
    cyc();
    chk("rma_c2_stall", stall, 1);
    reset = 1'b1; bus_rdy_n = 1'b0; bus_rdata = 32'h12345678; ex_en = 1'b0; #1;
    cyc();
    chk("rma_as_n", bus_as_n, 1);
    chk("rma_be", bus_be, 0);
    chk("rma_err", bus_err, 0);
    chk("rma_stall", stall, 0);
    chk("rma_out", out, 32'h400);
    reset = 1'b0; bus_rdy_n = 1'b1; #1;
    cyc();
    chk("rma_nodone_out", out, 32'h400);
    chk("rma_nodone_as_n", bus_as_n, 1);
    chk("rma_nodone_err", bus_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
